// File: rtl/sonar_scheduler.sv
// Round-robin HC-SR04 scheduler: triggers one masked channel per slot and
// measures its echo width in microsecond ticks.
module sonar_scheduler #(
    parameter int unsigned CLK_PER_US  = 40,
    parameter int unsigned NUM_SENSORS = 4,
    parameter int unsigned TRIG_US     = 20,
    parameter int unsigned SLOT_US     = 60000,
    parameter int unsigned MAX_US      = 3552
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensor_mask,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trig,
    output logic                   busy,
    output logic                   result_valid,
    output logic [1:0]             result_id,
    output logic [11:0]            result_us,
    output logic                   result_timeout
);

    localparam int unsigned PRESC_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int unsigned TMR_W   = 16;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned US_W    = 12;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_US - 1);
    localparam logic [TMR_W-1:0]   TRIG_LAST  = TMR_W'(TRIG_US - 1);
    localparam logic [TMR_W-1:0]   SLOT_LAST  = TMR_W'(SLOT_US - 1);
    localparam logic [US_W-1:0]    WIDTH_MAX  = US_W'(MAX_US);
    localparam logic [ID_W-1:0]    PTR_RST    = ID_W'(NUM_SENSORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_ECHO,
        S_MEASURE,
        S_DONE,
        S_HOLDOFF
    } state_t;

    state_t                 state_q, state_d;
    logic [PRESC_W-1:0]     presc_q, presc_d;
    logic [NUM_SENSORS-1:0] sync1_q, sync2_q;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [US_W-1:0]        width_q, width_d;
    logic [ID_W-1:0]        sel_q, sel_d;
    logic [NUM_SENSORS-1:0] trig_q, trig_d;
    logic                   busy_q, busy_d;
    logic                   result_valid_q, result_valid_d;
    logic [ID_W-1:0]        result_id_q, result_id_d;
    logic [US_W-1:0]        result_us_q, result_us_d;
    logic                   result_timeout_q, result_timeout_d;

    logic                   tick_c;
    logic                   echo_sel_c;
    logic                   any_mask_c;
    logic [ID_W-1:0]        next_sel_c;
    logic [TMR_W-1:0]       timer_inc_c;

    // Free-running microsecond prescaler
    always_comb begin
        tick_c  = (presc_q == PRESC_LAST);
        presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
    end

    // Synchronized echo of the channel currently being served
    always_comb begin
        echo_sel_c = 1'b0;
        for (int j = 0; j < int'(NUM_SENSORS); j++) begin
            if (sel_q == ID_W'(j)) begin
                echo_sel_c = sync2_q[j];
            end
        end
    end

    // Round robin: lowest masked index above the last served, else wrap to lowest
    always_comb begin
        logic            found_hi;
        logic [ID_W-1:0] hi_sel;
        logic [ID_W-1:0] lo_sel;
        found_hi   = 1'b0;
        hi_sel     = '0;
        lo_sel     = '0;
        any_mask_c = |sensor_mask;
        for (int j = int'(NUM_SENSORS) - 1; j >= 0; j--) begin
            if (sensor_mask[j] && (ID_W'(j) > sel_q)) begin
                found_hi = 1'b1;
                hi_sel   = ID_W'(j);
            end
            if (sensor_mask[j] && (ID_W'(j) <= sel_q)) begin
                lo_sel = ID_W'(j);
            end
        end
        next_sel_c = found_hi ? hi_sel : lo_sel;
    end

    // Slot timer saturates at the last slot tick so it can never wrap
    assign timer_inc_c = (timer_q == SLOT_LAST) ? timer_q : timer_q + TMR_W'(1);

    always_comb begin
        state_d          = state_q;
        timer_d          = timer_q;
        width_d          = width_q;
        sel_d            = sel_q;
        result_valid_d   = 1'b0;
        result_id_d      = result_id_q;
        result_us_d      = result_us_q;
        result_timeout_d = result_timeout_q;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                width_d = '0;
                if (tick_c && enable && any_mask_c) begin
                    sel_d   = next_sel_c;
                    state_d = S_TRIG;
                end
            end
            S_TRIG: begin
                if (tick_c) begin
                    timer_d = timer_inc_c;
                    if (timer_q == TRIG_LAST) begin
                        state_d = S_WAIT_ECHO;
                    end
                end
            end
            S_WAIT_ECHO: begin
                if (tick_c) begin
                    timer_d = timer_inc_c;
                    if (echo_sel_c) begin
                        width_d = US_W'(1);
                        state_d = S_MEASURE;
                    end else if (timer_q == SLOT_LAST) begin
                        width_d          = '0;
                        result_timeout_d = 1'b1;
                        state_d          = S_DONE;
                    end
                end
            end
            S_MEASURE: begin
                if (tick_c) begin
                    timer_d = timer_inc_c;
                    if (!echo_sel_c) begin
                        result_timeout_d = 1'b0;
                        state_d          = S_DONE;
                    end else if (timer_q == SLOT_LAST) begin
                        result_timeout_d = 1'b1;
                        state_d          = S_DONE;
                    end else if (width_q != WIDTH_MAX) begin
                        width_d = width_q + US_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (tick_c) begin
                    timer_d = timer_inc_c;
                    if (timer_q == SLOT_LAST) begin
                        timer_d = '0;
                        width_d = '0;
                        if (enable && any_mask_c) begin
                            sel_d   = next_sel_c;
                            state_d = S_TRIG;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Results are latched on the transition into DONE so they are valid with the strobe
        if (state_d == S_DONE) begin
            result_valid_d = 1'b1;
            result_id_d    = sel_q;
            result_us_d    = width_d;
        end
    end

    always_comb begin
        busy_d = (state_d != S_IDLE);
        trig_d = '0;
        for (int j = 0; j < int'(NUM_SENSORS); j++) begin
            trig_d[j] = (state_d == S_TRIG) && (sel_d == ID_W'(j));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            presc_q          <= '0;
            sync1_q          <= '0;
            sync2_q          <= '0;
            timer_q          <= '0;
            width_q          <= '0;
            sel_q            <= PTR_RST;
            trig_q           <= '0;
            busy_q           <= 1'b0;
            result_valid_q   <= 1'b0;
            result_id_q      <= '0;
            result_us_q      <= '0;
            result_timeout_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            presc_q          <= presc_d;
            sync1_q          <= echo;
            sync2_q          <= sync1_q;
            timer_q          <= timer_d;
            width_q          <= width_d;
            sel_q            <= sel_d;
            trig_q           <= trig_d;
            busy_q           <= busy_d;
            result_valid_q   <= result_valid_d;
            result_id_q      <= result_id_d;
            result_us_q      <= result_us_d;
            result_timeout_q <= result_timeout_d;
        end
    end

    assign trig           = trig_q;
    assign busy           = busy_q;
    assign result_valid   = result_valid_q;
    assign result_id      = result_id_q;
    assign result_us      = result_us_q;
    assign result_timeout = result_timeout_q;

endmodule
